wishbone_rr_arbiter: RTL
========================

Name: wishbone_rr_arbiter

Overview:
Parametrised N-to-1 Wishbone arbiter that merges NUM_MASTERS independent CPU-side Wishbone masters (ibus, dbus, peripheral, debug) onto one shared SoC Wishbone port.
It generalises the fixed split/merged ibus/dbus/idbus wiring to any master count, adding:
- round-robin fairness;
- cycle-locked grants for bursts and AMO sequences;
- a per-transaction watchdog that terminates hung slaves with an error.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 30, word-address width
DATA_W, 32, data width; byte-select width is DATA_W/8
TIMEOUT_CYCLES, 1024, stall cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, asynchronous, active-high
m_adr  in  NUM_MASTERS*ADDR_W  per-master address, master i in slice i
m_dat_w  in  NUM_MASTERS*DATA_W  per-master write data
m_sel  in  NUM_MASTERS*(DATA_W/8)  per-master byte selects
m_cyc, m_stb, m_we  in  NUM_MASTERS  per-master control bits
m_cti  in  NUM_MASTERS*3  per-master cycle type
m_bte  in  NUM_MASTERS*2  per-master burst type
m_dat_r  out  DATA_W  read data, broadcast to all masters
m_ack, m_err  out  NUM_MASTERS  per-master termination
s_adr, s_dat_w, s_sel, s_we, s_cti, s_bte  out  as above, single  shared-bus request
s_cyc, s_stb  out  1  shared-bus control
s_dat_r  in  DATA_W  shared-bus read data
s_ack, s_err  in  1  shared-bus termination
grant_idx  out  clog2(NUM_MASTERS)  current owner, for debug
busy  out  1  a grant is held

Behaviour:
Reset values (asynchronous):
- state=IDLE; last_grant=NUM_MASTERS-1, so master 0 wins first; watchdog=0.
- s_cyc=0, s_stb=0, m_ack=0, m_err=0, busy=0, grant_idx=0.

States:
- IDLE: s_cyc=0. A request is m_cyc[i]&m_stb[i]. If any request exists, pick the first requester scanning last_grant+1, +2, ... modulo NUM_MASTERS. Register grant_idx and last_grant, then go to BUSY.
  - Latency: request at cycle t, s_cyc/s_stb at t+1.
- BUSY, forwarding:
  - s_* follow the granted master's m_* combinationally.
  - m_ack[g]=s_ack and m_err[g]=s_err; every other master sees ack=0 and err=0.
- BUSY, grant hold: the grant is held while m_cyc[g]=1 across multiple stb beats (bursts, LR/SC, AMO read-modify-write). Other requests wait.
- BUSY, release: when m_cyc[g]=0, go to IDLE.
  - s_cyc drops the same cycle.
  - A s_ack in that cycle is discarded.
  - There is exactly one idle turnaround cycle between grants.
- Watchdog:
  - Increments each BUSY cycle with s_stb=1 & !s_ack & !s_err; clears on ack, err or new grant.
  - When it equals TIMEOUT_CYCLES (nonzero), pulse m_err[g]=1 for one cycle and enter ABORT.
- ABORT: s_cyc=s_stb=0, m_ack=m_err=0. Return to IDLE once m_cyc[g]=0. A late s_ack is ignored.
- Simultaneous s_ack and s_err: s_err wins; m_ack[g]=0, m_err[g]=1.
- Reset asserted mid-transaction: immediate return to IDLE; all outputs drop asynchronously.
- A request from a master whose m_cyc falls before it is granted is simply never served. No request is queued.

Decomposition:
Package wb_arb_pkg holds:
- typedef wb_req_t (adr, dat_w, sel, we, cti, bte);
- enum arb_state_t {IDLE, BUSY, ABORT};
- localparam IDX_W = $clog2(NUM_MASTERS).

Sub-module rr_priority_picker (combinational request vector + last_grant -> valid, index) is reused by future interrupt and L2 arbiters.

Test Plan:
1. Reset, then masters 0 and 1 request together. Master 0 is granted, s_cyc rises 1 cycle later, ack routes only to m_ack[0]. After m_cyc[0] falls, one idle cycle, then master 1 is granted.
2. NUM_MASTERS=4, all masters request continuously with single-beat cycles. Grant order is 0,1,2,3,0; no master waits more than 3 grants.
3. Master 1 runs a 4-beat burst (cti=2 then 7) while master 0 requests. Master 1 keeps the grant for all 4 acks; master 0 is granted only afterwards.
4. TIMEOUT_CYCLES=16, the slave never acks. m_err[g] pulses exactly at stall cycle 16 and s_cyc=0 in the next cycle. A late s_ack during ABORT produces no m_ack.
5. s_ack and s_err asserted in the same cycle. m_err[g]=1, m_ack[g]=0.
6. rst asserted while BUSY with s_stb=1. s_cyc=0 and busy=0 before the next clock edge. After reset release, master 0 has first priority.

Source files
------------

// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter
// and the priority pickers built on it.
package wb_arb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;

    typedef struct packed {
        logic [WB_ADR_W-1:0]   adr;
        logic [WB_DAT_W-1:0]   dat_w;
        logic [WB_DAT_W/8-1:0] sel;
        logic                  we;
        logic [2:0]            cti;
        logic [1:0]            bte;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wishbone_rr_arbiter_if.sv
// Bundle of the per-master CPU-side ports and the shared SoC port.
// Master i occupies slice i of every packed per-master field.
interface wishbone_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
    logic [NUM_MASTERS*DATA_W-1:0] m_dat_w;
    logic [NUM_MASTERS*SEL_W-1:0]  m_sel;
    logic [NUM_MASTERS-1:0]        m_cyc;
    logic [NUM_MASTERS-1:0]        m_stb;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*3-1:0]      m_cti;
    logic [NUM_MASTERS*2-1:0]      m_bte;
    logic [DATA_W-1:0]             m_dat_r;
    logic [NUM_MASTERS-1:0]        m_ack;
    logic [NUM_MASTERS-1:0]        m_err;

    logic [ADDR_W-1:0] s_adr;
    logic [DATA_W-1:0] s_dat_w;
    logic [SEL_W-1:0]  s_sel;
    logic              s_we;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              s_cyc;
    logic              s_stb;
    logic [DATA_W-1:0] s_dat_r;
    logic              s_ack;
    logic              s_err;

    modport master (
        output m_adr, m_dat_w, m_sel, m_cyc, m_stb, m_we, m_cti, m_bte,
        input  m_dat_r, m_ack, m_err
    );

    modport slave (
        input  s_adr, s_dat_w, s_sel, s_we, s_cti, s_bte, s_cyc, s_stb,
        output s_dat_r, s_ack, s_err
    );

    modport arbiter (
        input  m_adr, m_dat_w, m_sel, m_cyc, m_stb, m_we, m_cti, m_bte,
        output m_dat_r, m_ack, m_err,
        output s_adr, s_dat_w, s_sel, s_we, s_cti, s_bte, s_cyc, s_stb,
        input  s_dat_r, s_ack, s_err
    );

endinterface

// File: rtl/wishbone_rr_arbiter_picker.sv
// Round-robin picker: first set request after last, wrapping modulo N.
// Purely combinational so other arbiters can share it.
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    localparam int IDX_W = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    logic [2*NUM_MASTERS-1:0] dbl;
    logic [2*NUM_MASTERS-1:0] shifted;
    logic [NUM_MASTERS-1:0]   rot;

    assign dbl = {req, req};

    // rot[k] is the request of master (last + 1 + k) mod N
    always_comb begin
        shifted = dbl >> (int'(last) + 1);
        rot     = shifted[NUM_MASTERS-1:0];
        valid   = |req;
        idx     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = IDX_W'((int'(last) + 1 + k) % NUM_MASTERS);
            end
        end
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-to-1 round-robin Wishbone arbiter with cycle-locked grants
// and a per-transaction stall watchdog.
module wishbone_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    wishbone_rr_arbiter_if.arbiter              bus,
    output logic [idx_width(NUM_MASTERS)-1:0]   grant_idx,
    output logic                                busy
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int SEL_W = DATA_W / 8;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       last_grant;
    logic [WD_W-1:0]        wdog;
    logic [NUM_MASTERS-1:0] req;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   fwd;
    logic                   stall;
    logic                   timeout;
    logic [NUM_MASTERS-1:0] ack_v;
    logic [NUM_MASTERS-1:0] err_v;

    assign req = bus.m_cyc & bus.m_stb;

    rr_priority_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req  (req),
        .last (last_grant),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    assign g_cyc = bus.m_cyc[grant];
    assign g_stb = bus.m_stb[grant];
    assign fwd   = (state == BUSY) && g_cyc;

    assign bus.s_cyc   = fwd;
    assign bus.s_stb   = fwd && g_stb;
    assign bus.s_adr   = bus.m_adr[int'(grant)*ADDR_W +: ADDR_W];
    assign bus.s_dat_w = bus.m_dat_w[int'(grant)*DATA_W +: DATA_W];
    assign bus.s_sel   = bus.m_sel[int'(grant)*SEL_W +: SEL_W];
    assign bus.s_we    = bus.m_we[grant];
    assign bus.s_cti   = bus.m_cti[int'(grant)*3 +: 3];
    assign bus.s_bte   = bus.m_bte[int'(grant)*2 +: 2];
    assign bus.m_dat_r = bus.s_dat_r;

    assign stall   = bus.s_stb && !bus.s_ack && !bus.s_err;
    assign timeout = (TIMEOUT_CYCLES != 0) && stall && (wdog == WD_LAST);

    // s_err dominates a simultaneous s_ack
    always_comb begin
        ack_v = '0;
        err_v = '0;
        if (fwd) begin
            ack_v[grant] = bus.s_ack && !bus.s_err;
            err_v[grant] = bus.s_err || timeout;
        end
    end

    assign bus.m_ack = ack_v;
    assign bus.m_err = err_v;
    assign grant_idx = grant;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            wdog       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wdog <= '0;
                    if (pick_valid) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.s_ack || bus.s_err) begin
                        wdog <= '0;
                    end else if (stall) begin
                        wdog <= wdog + WD_W'(1);
                    end
                    if (!g_cyc) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    wdog <= '0;
                    if (!g_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
